fft_seq_ctrl: RTL and testbench
===============================

// Module: fft_seq_ctrl
// PURPOSE
//  Sequencer for the 8-point FFT coprocessor. On a start command it streams 16 words (re/im interleaved, x0..x7)
//  from data memory into the FFT unit with LOAD ops, then issues 6 CAL ops and waits for butterfly-3 ready.
//  It then drains 16 result words with EXPORT ops and writes them back to memory.
//  Sits between the core's FFT command CSR and the FFT unit/data-memory ports, replacing per-word ALU ops.
// PARAMETERS
//  DATA_W      32  data word width (= instWidth)
//  ADDR_W      32  memory byte-address width
//  OP_W        5   FFT aluop width (= aluOP)
//  OP_NOP      0   aluop driven when no FFT op is issued
//  OP_LOAD     1   aluop code for FFT load (set to `aluFFTLoad at instantiation)
//  OP_CAL      2   aluop code for FFT calculate (`aluFFTCAL)
//  OP_EXPORT   3   aluop code for FFT export (`aluFFTExport)
//  STRIDE      4   byte increment between consecutive words
//  WAIT_MAX    64  max cycles in WAIT before timeout
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       1-cycle command pulse; sampled only in IDLE
//  src_addr   in   ADDR_W  source base address, captured on accepted start
//  dst_addr   in   ADDR_W  destination base address, captured on accepted start
//  busy       out  1       high from cycle after accepted start through DONE
//  done       out  1       1-cycle pulse at end of sequence
//  err        out  1       sticky timeout flag; cleared by next accepted start
//  rd_en      out  1       memory read strobe
//  rd_addr    out  ADDR_W  memory read address
//  rd_data    in   DATA_W  read data, valid the cycle after rd_en
//  wr_en      out  1       memory write strobe
//  wr_addr    out  ADDR_W  memory write address
//  wr_data    out  DATA_W  memory write data
//  fft_op     out  OP_W    aluop to FFT unit
//  fft_src    out  DATA_W  dataSrc to FFT unit
//  fft_dout   in   DATA_W  fftData from FFT unit, valid the cycle after an EXPORT edge
//  fft_ready  in   1       butterfly3_ready from FFT unit
// BEHAVIOUR
//  Reset values:
//  - all outputs 0, fft_op=OP_NOP, state IDLE, counters 0.
//  - Reset mid-sequence aborts immediately with no done pulse.
//  - FFT-unit internal state is cleared by the same system reset.
//  States: IDLE -> LOAD -> CAL -> WAIT -> EXPORT -> DRAIN -> DONE -> IDLE. Cycle N = cycle after the start edge.
//  IDLE:
//  - start=1 captures src/dst, clears err, selects LOAD.
//  - start in any other state is ignored (no queueing).
//  LOAD (cycles 1..17):
//  - idx 0..15 issues rd_en with rd_addr=src+STRIDE*idx in cycles 1..16.
//  - Each read is followed next cycle by fft_op=OP_LOAD with fft_src=rd_data (combinational pass), cycles 2..17.
//  - fft_src=0 whenever fft_op!=OP_LOAD.
//  CAL (cycles 18..23): exactly 6 consecutive cycles of fft_op=OP_CAL.
//  WAIT (cycle 24 onward):
//  - fft_op=OP_NOP until fft_ready=1, then EXPORT.
//  - If WAIT_MAX cycles pass without ready: set err, go to DONE, skip EXPORT, no writes.
//  EXPORT (16 cycles): fft_op=OP_EXPORT, idx 0..15.
//  DRAIN:
//  - Writes lag EXPORT by one cycle: wr_en=1, wr_addr=dst+STRIDE*k, wr_data=fft_dout for k=0..15.
//  - The last write occurs in DRAIN; DRAIN is one cycle.
//  DONE: done=1 for one cycle, busy drops, returns to IDLE. Back-to-back start is accepted in the following IDLE cycle.
//  Latency: fft_ready present by cycle 24 -> EXPORT 24..39, writes 25..40, done at 41.
//  Counting and addresses:
//  - idx is a 4-bit counter; wrap 15->0 coincides with state change.
//  - Addresses are modulo 2^ADDR_W, wrap allowed and not flagged.
//  - No overlap checks between src and dst regions; in-place (src==dst) is legal because all reads precede all writes.
//  - rd_en and wr_en are never high in the same cycle.
// TESTING
//  T1 mem[0..15]=impulse {1,0,0...}, src=0, dst=0x100, ready by cyc 24 -> all 8 re outputs = FFT scale of 1, im=0;
//     done at cycle 41.
//  T2 Cycle trace -> exactly 16 LOAD, 6 CAL, 16 EXPORT ops; wr_addr 0x100..0x13C step 4; no rd/wr overlap.
//  T3 fft_ready held low 10 extra cycles -> EXPORT starts cycle after ready rises; done = 41+10.
//  T4 fft_ready never rises, WAIT_MAX=64 -> err=1, no wr_en, done pulses.
//     Next start clears err; T1 then passes.
//  T5 start pulsed during LOAD and EXPORT -> ignored; single done. Restart in IDLE the cycle after done -> accepted.
//  T6 rst asserted at cycle 20 (CAL) -> outputs to reset values asynchronously, no done.
//     Fresh start after reset -> T1 result.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// FFT coprocessor sequencer: streams 16 words from memory into the FFT unit, runs 6 CAL ops,
// waits for butterfly-3 ready, then exports 16 results and writes them back to memory.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | 16 reads, each forwarded as a LOAD op one cycle later
// CAL    | 6 consecutive CAL ops
// WAIT   | waiting for butterfly-3 ready, bounded by WAIT_MAX
// EXPORT | 16 EXPORT ops, write-back trails by one cycle
// DRAIN  | write-back of the last exported word
// DONE   | one-cycle done pulse

module fft_seq_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int OP_W      = 5,
   parameter int OP_NOP    = 0,
   parameter int OP_LOAD   = 1,
   parameter int OP_CAL    = 2,
   parameter int OP_EXPORT = 3,
   parameter int STRIDE    = 4,
   parameter int WAIT_MAX  = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic [OP_W-1:0]   fft_op_o,
   output logic [DATA_W-1:0] fft_src_o,
   input  logic [DATA_W-1:0] fft_dout_i,
   input  logic              fft_ready_i
);

   localparam int WAIT_CW = $clog2(WAIT_MAX + 1);
   localparam int N_CAL   = 6;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CAL, S_WAIT, S_EXPORT, S_DRAIN, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic [WAIT_CW-1:0]   wait_q, wait_d;
   logic [ADDR_W-1:0]    src_q, dst_q;
   logic                 err_q;
   logic                 ld_pend_q;
   logic                 wr_pend_q;
   logic [3:0]           wr_idx_q;
   logic                 rd_en;
   logic                 accept;
   logic                 timeout;

   function automatic logic [ADDR_W-1:0] word_off(input logic [3:0] i);
      return ADDR_W'(STRIDE) * ADDR_W'(i);
   endfunction

   // LOAD ends on the cycle that forwards the 16th word: pending load with idx already wrapped to 0
   assign rd_en   = (state_q == S_LOAD) && !(ld_pend_q && (idx_q == 4'd0));
   assign accept  = (state_q == S_IDLE) && start_i;
   assign timeout = (state_q == S_WAIT) && !fft_ready_i && (wait_q == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = 4'd0;
      wait_d  = WAIT_CW'(WAIT_MAX - 1);
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            idx_d = rd_en ? idx_q + 4'd1 : idx_q;
            if (!rd_en) state_d = S_CAL;
         end
         S_CAL: begin
            if (idx_q == 4'(N_CAL - 1)) begin
               state_d = fft_ready_i ? S_EXPORT : S_WAIT;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_WAIT: begin
            wait_d = (wait_q != '0) ? wait_q - 1'b1 : wait_q;
            if (fft_ready_i)       state_d = S_EXPORT;
            else if (wait_q == '0) state_d = S_DONE;
         end
         S_EXPORT: begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q     <= 4'd0;
         wait_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         err_q     <= 1'b0;
         ld_pend_q <= 1'b0;
         wr_pend_q <= 1'b0;
         wr_idx_q  <= 4'd0;
      end else begin
         idx_q     <= idx_d;
         wait_q    <= wait_d;
         ld_pend_q <= rd_en;
         wr_pend_q <= (state_q == S_EXPORT);
         wr_idx_q  <= idx_q;
         if (accept) begin
            src_q <= src_addr_i;
            dst_q <= dst_addr_i;
         end
         if (accept)       err_q <= 1'b0;
         else if (timeout) err_q <= 1'b1;
      end
   end

   always_comb begin
      busy_o    = (state_q != S_IDLE);
      done_o    = (state_q == S_DONE);
      err_o     = err_q;
      rd_en_o   = rd_en;
      rd_addr_o = rd_en ? src_q + word_off(idx_q) : '0;
      fft_op_o  = OP_W'(OP_NOP);
      fft_src_o = '0;
      if (ld_pend_q) begin
         fft_op_o  = OP_W'(OP_LOAD);
         fft_src_o = rd_data_i;
      end else if (state_q == S_CAL) begin
         fft_op_o  = OP_W'(OP_CAL);
      end else if (state_q == S_EXPORT) begin
         fft_op_o  = OP_W'(OP_EXPORT);
      end
      wr_en_o   = wr_pend_q;
      wr_addr_o = wr_pend_q ? dst_q + word_off(wr_idx_q) : '0;
      wr_data_o = wr_pend_q ? fft_dout_i : '0;
   end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: memory and FFT-unit models, table-driven and randomized sequences
// checked against a cycle-level reference of the expected transaction timeline.

module tb_fft_seq_ctrl;

   localparam int WMAX = 64;
   localparam logic [4:0] OP_NOP    = 5'd0;
   localparam logic [4:0] OP_LOAD   = 5'd1;
   localparam logic [4:0] OP_CAL    = 5'd2;
   localparam logic [4:0] OP_EXPORT = 5'd3;
   localparam real PI = 3.14159265358979;

   typedef logic [15:0][31:0] blk_t;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          ready_at;
      int          xs1;
      int          xs2;
      bit          impulse;
      int          exp_done;
      int          exp_err;
      int          exp_nwr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, ready;
   logic [31:0] src_addr, dst_addr;
   logic [31:0] rd_data = '0;
   logic [31:0] fft_dout = '0;
   logic        busy, done, err, rd_en, wr_en;
   logic [31:0] rd_addr, wr_addr, wr_data, fft_src;
   logic [4:0]  fft_op;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fft_seq_ctrl #(
      .DATA_W(32), .ADDR_W(32), .OP_W(5), .OP_NOP(0), .OP_LOAD(1), .OP_CAL(2),
      .OP_EXPORT(3), .STRIDE(4), .WAIT_MAX(WMAX)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .src_addr_i(src_addr), .dst_addr_i(dst_addr),
      .busy_o(busy), .done_o(done), .err_o(err),
      .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
      .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .fft_op_o(fft_op), .fft_src_o(fft_src), .fft_dout_i(fft_dout),
      .fft_ready_i(ready)
   );

   // data memory: sparse, byte-addressed words
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem_rd(rd_addr);
      if (wr_en) mem[wr_addr] = wr_data;
   end

   // 8-point DFT on interleaved re/im words, rounded to nearest integer
   function automatic logic [31:0] rnd(input real v);
      int i;
      i = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      return 32'(i);
   endfunction

   function automatic blk_t dft(input blk_t x);
      blk_t y;
      real re, im, ang, xr, xi;
      for (int k = 0; k < 8; k++) begin
         re = 0.0;
         im = 0.0;
         for (int n = 0; n < 8; n++) begin
            ang = -2.0 * PI * real'(k * n) / 8.0;
            xr  = $itor($signed(x[2*n]));
            xi  = $itor($signed(x[2*n+1]));
            re  = re + xr * $cos(ang) - xi * $sin(ang);
            im  = im + xr * $sin(ang) + xi * $cos(ang);
         end
         y[2*k]   = rnd(re);
         y[2*k+1] = rnd(im);
      end
      return y;
   endfunction

   // behavioural FFT unit
   blk_t       fbuf, fres;
   logic [3:0] ld_cnt, ex_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_cnt   <= 4'd0;
         ex_cnt   <= 4'd0;
         fft_dout <= '0;
      end else begin
         case (fft_op)
            OP_LOAD: begin
               fbuf[ld_cnt] <= fft_src;
               ld_cnt       <= ld_cnt + 4'd1;
            end
            OP_CAL:  fres <= dft(fbuf);
            OP_EXPORT: begin
               fft_dout <= fres[ex_cnt];
               ex_cnt   <= ex_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string name, input longint act, input longint expv);
      n_vec++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic int outs_active();
      return int'(busy | done | err | rd_en | wr_en | (|fft_op) | (|fft_src) |
                  (|rd_addr) | (|wr_addr) | (|wr_data));
   endfunction

   // timeline from the sequencing rules: EXPORT begins the cycle after ready is seen, never before 24
   function automatic void ref_timing(input int ready_at, output int d, output int e, output int nw);
      int xs;
      xs = (ready_at + 1 > 24) ? ready_at + 1 : 24;
      if (xs > 24 + WMAX) begin
         d = 24 + WMAX; e = 1; nw = 0;
      end else begin
         d = xs + 17;   e = 0; nw = 16;
      end
   endfunction

   task automatic run_vec(input string name, input vec_t v);
      blk_t        img, expb;
      logic [31:0] w;
      int done_c, nrd, nld, ncal, nex, nwr;
      int bad_rd, bad_ld, bad_cal, bad_src, bad_wr, bad_busy, ovl, bad_op, ok_imp;
      done_c = -1;
      nrd = 0; nld = 0; ncal = 0; nex = 0; nwr = 0;
      bad_rd = 0; bad_ld = 0; bad_cal = 0; bad_src = 0; bad_wr = 0;
      bad_busy = 0; ovl = 0; bad_op = 0;
      for (int i = 0; i < 16; i++) begin
         w = v.impulse ? ((i == 0) ? 32'd1 : 32'd0) : 32'($urandom_range(0, 2000)) - 32'd1000;
         mem[v.src + 32'(4 * i)] = w;
         img[i] = w;
      end
      expb = dft(img);
      @(negedge clk);
      chk({name, " idle before start"}, {busy, done}, 0);
      src_addr = v.src;
      dst_addr = v.dst;
      start    = 1'b1;
      ready    = (v.ready_at <= 0);
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = (c == v.xs1) || (c == v.xs2);
         ready = (c >= v.ready_at);
         src_addr = $urandom();
         dst_addr = $urandom();
         if (busy !== 1'b1) bad_busy++;
         if (rd_en && wr_en) ovl++;
         if (rd_en) begin
            nrd++;
            if (c > 16 || rd_addr !== v.src + 32'(4 * (c - 1))) bad_rd++;
         end
         if (fft_op == OP_LOAD) begin
            nld++;
            if (c < 2 || c > 17) bad_ld++;
            else if (fft_src !== img[4'(c - 2)]) bad_ld++;
         end else begin
            if (fft_src !== 32'h0) bad_src++;
            if (fft_op == OP_CAL) begin
               ncal++;
               if (c < 18 || c > 23) bad_cal++;
            end else if (fft_op == OP_EXPORT) begin
               nex++;
            end else if (fft_op != OP_NOP) begin
               bad_op++;
            end
         end
         if (wr_en) begin
            if (nwr >= 16) bad_wr++;
            else if (c != v.exp_done - 16 + nwr || wr_addr !== v.dst + 32'(4 * nwr) ||
                     wr_data !== expb[nwr]) bad_wr++;
            nwr++;
         end
         if (done) begin
            done_c = c;
            break;
         end
      end
      start = 1'b0;
      ready = 1'b0;
      chk({name, " done cycle"}, done_c, v.exp_done);
      chk({name, " err"}, err, v.exp_err);
      chk({name, " read count"}, nrd, 16);
      chk({name, " read addr/timing"}, bad_rd, 0);
      chk({name, " load count"}, nld, 16);
      chk({name, " load data/timing"}, bad_ld, 0);
      chk({name, " cal count"}, ncal, 6);
      chk({name, " cal timing"}, bad_cal, 0);
      chk({name, " export count"}, nex, v.exp_nwr);
      chk({name, " write count"}, nwr, v.exp_nwr);
      chk({name, " write addr/data/timing"}, bad_wr, 0);
      chk({name, " rd/wr overlap"}, ovl, 0);
      chk({name, " busy"}, bad_busy, 0);
      chk({name, " fft_src gating/op"}, bad_src + bad_op, 0);
      if (v.impulse && v.exp_nwr == 16) begin
         ok_imp = 1;
         for (int k = 0; k < 8; k++)
            if (mem_rd(v.dst + 32'(8 * k)) !== 32'd1 || mem_rd(v.dst + 32'(8 * k + 4)) !== 32'd0)
               ok_imp = 0;
         chk({name, " impulse spectrum"}, ok_imp, 1);
      end
   endtask

   vec_t tbl [9];
   vec_t rv;
   int   d, e, nw, nd;

   initial begin
      //          src            dst            rdy     xs1 xs2 imp  done err nwr
      tbl[0] = '{32'h0,         32'h100,       1,      0,  0,  1'b1, 41,  0,  16};
      tbl[1] = '{32'h0,         32'h100,       33,     0,  0,  1'b1, 51,  0,  16};
      tbl[2] = '{32'h200,       32'h300,       100000, 0,  0,  1'b0, 88,  1,  0};
      tbl[3] = '{32'h0,         32'h100,       1,      0,  0,  1'b1, 41,  0,  16};
      tbl[4] = '{32'h40,        32'h400,       1,      5,  30, 1'b0, 41,  0,  16};
      tbl[5] = '{32'h800,       32'h800,       20,     0,  0,  1'b0, 41,  0,  16};
      tbl[6] = '{32'hFFFF_FFF8, 32'hFFFF_FFE0, 24,     0,  0,  1'b0, 42,  0,  16};
      tbl[7] = '{32'h1000,      32'h2000,      87,     0,  0,  1'b0, 105, 0,  16};
      tbl[8] = '{32'h1000,      32'h2000,      88,     0,  0,  1'b0, 88,  1,  0};

      rst = 1'b1; start = 1'b0; ready = 1'b0; src_addr = '0; dst_addr = '0;
      #1;
      chk("reset outputs", outs_active(), 0);
      chk("reset fft_op", fft_op, OP_NOP);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int t = 0; t < 9; t++) run_vec($sformatf("tbl%0d", t), tbl[t]);

      // reset while in CAL aborts with no done, then a fresh start behaves normally
      for (int i = 0; i < 16; i++) mem[32'(4 * i)] = (i == 0) ? 32'd1 : 32'd0;
      @(negedge clk);
      src_addr = 32'h0; dst_addr = 32'h500; start = 1'b1; ready = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      chk("rst test in cal at 20", fft_op, OP_CAL);
      rst = 1'b1;
      #1;
      chk("rst test async outputs", outs_active(), 0);
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("rst test no done/busy", nd, 0);
      rst = 1'b0;
      ready = 1'b0;
      run_vec("after rst", '{32'h0, 32'h500, 1, 0, 0, 1'b1, 41, 0, 16});

      for (int r = 0; r < 10; r++) begin
         rv.src      = $urandom() & 32'hFFFF_FFFC;
         rv.dst      = (r % 3 == 0) ? rv.src : ($urandom() & 32'hFFFF_FFFC);
         rv.ready_at = (r % 4 == 3) ? 100000 : int'($urandom_range(1, 60));
         rv.xs1      = int'($urandom_range(1, 40));
         rv.xs2      = 0;
         rv.impulse  = 1'b0;
         ref_timing(rv.ready_at, d, e, nw);
         rv.exp_done = d;
         rv.exp_err  = e;
         rv.exp_nwr  = nw;
         run_vec($sformatf("rand%0d", r), rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
